// File: rtl/ex_div_pkg.sv
// Shared definitions for the execute-stage divider: bus widths, state
// encodings and handshake constants.
package ex_div_pkg;

    localparam int RegBus       = 32;
    localparam int DoubleRegBus = 64;

    localparam logic [RegBus-1:0] ZeroWord = 32'h0000_0000;

    localparam logic DivResultReady    = 1'b1;
    localparam logic DivResultNotReady = 1'b0;
    localparam logic DivStart          = 1'b1;
    localparam logic DivStop           = 1'b0;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } divState_e;

endpackage

// File: rtl/ex_div_if.sv
// Request/response bundle between the EX stage (master) and the divider (slave).
interface ex_div_if;
    import ex_div_pkg::*;

    logic                    signed_div_i;
    logic [RegBus-1:0]       opdata1_i;
    logic [RegBus-1:0]       opdata2_i;
    logic                    start_i;
    logic                    annul_i;
    logic [DoubleRegBus-1:0] result_o;
    logic                    ready_o;
    logic                    busy_o;

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
    );

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
    );

endinterface

// File: rtl/ex_div.sv
// Radix-2 restoring divider, one quotient bit per cycle; result is
// {remainder, quotient} with truncate-toward-zero signed semantics.
module ex_div
    import ex_div_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    ex_div_if.slave  div
);

    divState_e               state_q, state_d;
    logic [5:0]              cnt_q, cnt_d;
    logic [64:0]             work_q, work_d;
    logic [RegBus-1:0]       divisor_q, divisor_d;
    logic                    dividendNeg_q, dividendNeg_d;
    logic                    divisorNeg_q, divisorNeg_d;
    logic [DoubleRegBus-1:0] result_q, result_d;
    logic                    ready_q, ready_d;

    logic [32:0]             diff;
    logic [RegBus-1:0]       dividendAbs;
    logic [RegBus-1:0]       divisorAbs;
    logic [RegBus-1:0]       quotFixed;
    logic [RegBus-1:0]       remFixed;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= DivFree;
            cnt_q         <= '0;
            work_q        <= '0;
            divisor_q     <= ZeroWord;
            dividendNeg_q <= 1'b0;
            divisorNeg_q  <= 1'b0;
            result_q      <= '0;
            ready_q       <= DivResultNotReady;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            work_q        <= work_d;
            divisor_q     <= divisor_d;
            dividendNeg_q <= dividendNeg_d;
            divisorNeg_q  <= divisorNeg_d;
            result_q      <= result_d;
            ready_q       <= ready_d;
        end
    end

    // Absolute values are taken only for DIV; signs are latched as "negate later" flags.
    assign dividendAbs = (div.signed_div_i && div.opdata1_i[31]) ? -div.opdata1_i : div.opdata1_i;
    assign divisorAbs  = (div.signed_div_i && div.opdata2_i[31]) ? -div.opdata2_i : div.opdata2_i;
    assign diff        = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    assign quotFixed   = (dividendNeg_q ^ divisorNeg_q) ? -work_q[31:0] : work_q[31:0];
    assign remFixed    = dividendNeg_q ? -work_q[64:33] : work_q[64:33];

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        work_d        = work_q;
        divisor_d     = divisor_q;
        dividendNeg_d = dividendNeg_q;
        divisorNeg_d  = divisorNeg_q;
        result_d      = result_q;
        ready_d       = ready_q;

        unique case (state_q)
            DivFree: begin
                if (div.start_i == DivStart && !div.annul_i) begin
                    if (div.opdata2_i == ZeroWord) begin
                        state_d = DivByZero;
                    end else begin
                        state_d       = DivOn;
                        cnt_d         = '0;
                        work_d        = {ZeroWord, dividendAbs, 1'b0};
                        divisor_d     = divisorAbs;
                        dividendNeg_d = div.signed_div_i && div.opdata1_i[31];
                        divisorNeg_d  = div.signed_div_i && div.opdata2_i[31];
                    end
                end
            end
            DivByZero: begin
                result_d = '0;
                if (div.annul_i) begin
                    state_d = DivFree;
                    ready_d = DivResultNotReady;
                end else begin
                    state_d = DivEnd;
                    ready_d = DivResultReady;
                end
            end
            DivOn: begin
                if (div.annul_i) begin
                    state_d  = DivFree;
                    cnt_d    = '0;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end else if (cnt_q != 6'd32) begin
                    // A borrow means the trial subtraction failed: shift in 0 and keep the remainder.
                    if (diff[32]) begin
                        work_d = {work_q[63:0], 1'b0};
                    end else begin
                        work_d = {diff[31:0], work_q[31:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end else begin
                    result_d = {remFixed, quotFixed};
                    ready_d  = DivResultReady;
                    state_d  = DivEnd;
                end
            end
            DivEnd: begin
                if (div.start_i == DivStop) begin
                    state_d  = DivFree;
                    result_d = '0;
                    ready_d  = DivResultNotReady;
                end
            end
            default: begin
                state_d = DivFree;
            end
        endcase
    end

    // Stall must already be asserted in the cycle the request first appears.
    assign div.busy_o   = (div.start_i == DivStart) && !(state_q == DivFree && div.annul_i);
    assign div.result_o = result_q;
    assign div.ready_o  = ready_q;

endmodule

// File: doc/ex_div.md
# ex_div

Multi-cycle 32-bit integer divider in the execute stage. It consumes the operands and ALU op delivered by the ID/EX pipeline register for DIV/DIVU and returns the quotient in LO and the remainder in HI. It uses radix-2 restoring division, one quotient bit per cycle. While busy, the EX stage raises a pipeline stall so ID/EX holds its contents.

## Interface
Parameters: none. Widths come from the shared `RegBus` (32) and `DoubleRegBus` (64) definitions.

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- signed_div_i  in  1  1 = DIV (signed), 0 = DIVU
- opdata1_i  in  32  dividend
- opdata2_i  in  32  divisor
- start_i  in  1  request from EX; held high until the result is consumed
- annul_i  in  1  cancel the operation in flight (flush/exception)
- result_o  out  64  {remainder[63:32], quotient[31:0]}; reset 0
- ready_o  out  1  result valid; reset 0
- busy_o  out  1  high in BYZERO/ON/END while start_i is high, i.e. the EX stall request; reset 0

## Operation
- States: FREE, BYZERO, ON, END. Reset enters FREE, clears the counter, the 65-bit work register, result_o and ready_o.
- FREE
  - start_i=1, annul_i=0, divisor=0: go to BYZERO.
  - start_i=1, annul_i=0, divisor≠0: go to ON. Load the work register with {32'b0, |dividend|, 1'b0} and latch |divisor|. Use absolute values only when signed_div_i=1. Latch both operand signs. Set cnt=0.
  - annul_i=1 wins over start_i; stay in FREE.
- BYZERO
  - Next edge: go to END with result_o=0 and ready_o=1.
  - annul_i=1: go to FREE instead.
- ON
  - While cnt<32, each edge performs one step. Compute diff = work[63:32] − divisor, 33-bit.
    - Negative: work <= {work[63:0], 1'b0}.
    - Otherwise: work <= {diff[31:0], work[31:0], 1'b1}.
    - Then cnt++.
  - At cnt==32, do the sign fix:
    - quotient = work[31:0], negated if the signs differ under signed mode;
    - remainder = work[64:33], negated if the dividend is negative under signed mode.
    - Load result_o, set ready_o=1, go to END.
  - annul_i=1 in any ON cycle: go to FREE, clear cnt, result_o=0, ready_o=0.
- END
  - Hold result_o and ready_o while start_i=1.
  - start_i=0: go to FREE; result_o=0 and ready_o=0 at the next edge.
- Arithmetic is modulo 2^32.
  - 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0. No trap.
  - Signed remainder takes the dividend's sign; the quotient truncates toward zero.
- Operand inputs are sampled only on the FREE→ON/BYZERO edge. Later changes are ignored.

## Timing
- Nonzero divisor: start sampled at edge E0, iterations at E1..E32, result at E33. ready_o is high in the cycle after E33, 33 cycles after acceptance.
- Zero divisor: ready_o is high after E1.
- busy_o is combinational from state and start_i.
  - It is high from the cycle start_i rises until the cycle ready_o=1. EX masks it once ready_o=1.
  - It is 0 in FREE, except in the cycle start is first seen, when it must already be 1. This is so ID/EX stalls from the first cycle.
- Back-to-back divides: start_i must drop for at least one cycle (END→FREE) before the next request is accepted.
- rst mid-operation: FREE at the next edge, all outputs 0, regardless of annul_i or start_i.

## Structure
- Add to the shared define file:
  - state encodings `DivFree`, `DivByZero`, `DivOn`, `DivEnd` (2 bits);
  - `DivResultReady` / `DivResultNotReady`;
  - `DivStart` / `DivStop`;
  - `DoubleRegBus`;
  - `ZeroWord`.
- No sub-module needed. The restoring-step subtractor and sign fix stay inline; the block is a single FSM plus datapath, about 150–200 lines.
- EX-stage integration (the wrapper instantiates ex_div):
  - drives start_i from aluop ∈ {DIV, DIVU} && !ready_o;
  - ORs busy_o into the stall request to the pipeline controller.

## Test plan
- DIVU 100 / 7: result_o = {0x00000002, 0x0000000E}, ready_o exactly 33 cycles after acceptance, busy_o high throughout.
- DIV −7 / 2 (0xFFFFFFF9 / 2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Also check DIV 7 / −2: quotient 0xFFFFFFFD, remainder 0x00000001.
- DIVU 0x12345678 / 0: ready_o after 2 cycles, result_o = 0. Then drop start_i: ready_o=0 on the next edge.
- DIV 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0. Also check DIVU 0xFFFFFFFF / 1: quotient 0xFFFFFFFF, remainder 0.
- Start DIVU 1000/3 and assert annul_i at iteration 10: FREE next edge, ready_o never rises. Then issue 9/3 immediately: quotient 3, remainder 0 after 33 cycles.
- Hold start_i 5 cycles in END: result_o stable and ready_o=1 throughout. Assert rst during ON: all outputs 0 at the next edge and the state is FREE.
